sensor_monitor: RTL and testbench
=================================

# sensor_monitor

Parametrised, registered successor to the combinational sensor error detector. It watches `NUM_SENSORS` sensor lines and debounces each one individually. It evaluates a configurable error rule, either any critical sensor, or the anchor sensor together with any companion sensor. Detected faults are held in a sticky flag until software clears them, with source capture and a fault counter. It sits between raw sensor pins and the system fault/interrupt logic.

## Interface
- `NUM_SENSORS`, 4: number of sensor inputs (≥2).
- `CRIT_MASK`, 4'b0001: sensors that raise an error alone.
- `ANCHOR_IDX`, 1: sensor index that raises an error together with any companion.
- `COMP_MASK`, 4'b1100: companion sensors for `ANCHOR_IDX`.
- `DEBOUNCE`, 3: consecutive samples required before a filtered sensor changes (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sensors`  in  NUM_SENSORS  raw sensor levels.
- `sensor_en`  in  NUM_SENSORS  per-sensor enable; 0 removes that sensor from the rule.
- `clear_error`  in  1  single-cycle request to clear the sticky state.
- `error`  out  1  live filtered fault.
- `error_latched`  out  1  sticky fault.
- `fault_src`  out  NUM_SENSORS  contributing sensors since the last clear.
- `fault_count`  out  8  number of fault entries, saturating.

## Operation
- **Filter (per sensor):**
  - Holds `filt[i]` and a counter.
  - Each edge where `sensors[i] != filt[i]`, the counter increments; on any edge where they match, the counter resets to 0.
  - When the counter reaches `DEBOUNCE`, `filt[i]` takes the new value and the counter resets.
- **Rule:**
  - `act = filt & sensor_en`.
  - `rule = |(act & CRIT_MASK) | (act[ANCHOR_IDX] & |(act & COMP_MASK))`.
- **FSM states:** NORMAL, FAULT, RECOVERED.
  - NORMAL→FAULT when `rule`.
  - FAULT→RECOVERED when `!rule`.
  - RECOVERED→FAULT when `rule`. `rule` has priority over `clear_error`.
  - RECOVERED→NORMAL when `clear_error && !rule`.
  - `clear_error` is ignored in NORMAL and in FAULT.
- **Outputs:**
  - `error` = (state==FAULT).
  - `error_latched` = (state!=NORMAL).
- **fault_src:**
  - In FAULT, each edge ORs in the contributing bits: the critical bits of `act`, plus the anchor and companion bits of `act` when the pair term holds.
  - Cleared to 0 on the RECOVERED→NORMAL transition.
- **fault_count:**
  - Increments on every transition into FAULT; saturates at 255.
  - Cleared only by `rst`.
- **Reset:** all outputs 0, all `filt` 0, all counters 0, state NORMAL. Reset takes effect immediately, including mid-FAULT or mid-debounce.

## Timing
- All outputs are registered; no combinational path from input to output.
- Raw input held from edge k: `filt` updates at edge k+DEBOUNCE−1; state and `error` update at edge k+DEBOUNCE.
  - Input-to-`error` latency is DEBOUNCE+1 edges in both directions.
- `fault_src` gets its first bits on the edge after entering FAULT.
- The `fault_count` increment is visible the same edge as `error` rises.
- `clear_error` sampled at edge n in RECOVERED → `error_latched`=0 and `fault_src`=0 after edge n.
- A pulse shorter than DEBOUNCE samples is fully rejected; a mismatch streak broken by one matching sample restarts the count.
- Changing `sensor_en` takes effect on `rule` immediately, with no debounce; state follows on the next edge.

## Structure
- `sensor_pkg`: `state_t` enum (NORMAL, FAULT, RECOVERED) and a `clog2`-based counter-width constant for `DEBOUNCE`.
- Sub-module `sensor_filter`: one debounce channel (`clk`, `rst`, `in`, `filt`), parameter `DEBOUNCE`, instantiated with a generate loop.
- The top level holds the rule logic, FSM, `fault_src` and `fault_count`.

## Test plan
- Reset with all inputs toggling → all outputs 0 on `rst` assertion and while held.
- `sensors`=4'b0001, `sensor_en`=4'b1111, DEBOUNCE=3, held → `error`=1 after the 4th edge; `fault_src`=4'b0001; `fault_count`=1.
- `sensors`=4'b0110 → error with `fault_src`=4'b0110; 4'b0010 or 4'b1100 alone → `error` stays 0.
- Glitch: `sensors[0]` high for 2 cycles, or 1-0-1-1 patterns → no error; `filt` unchanged.
- Recovery: fault, then `sensors`=0 → `error` falls after 4 edges, `error_latched`=1; `clear_error` in FAULT is ignored; `clear_error` in RECOVERED → `error_latched`=0, `fault_src`=0; clear coinciding with re-fault → FAULT, `fault_count`=2.
- `sensor_en`=4'b1110 with `sensors`=4'b0001 → no error; 256 fault entries → `fault_count`=255; `rst` mid-FAULT → immediate zeros.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and sizing helpers for the sensor monitor slice.
package sensor_pkg;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    FAULT     = 2'd1,
    RECOVERED = 2'd2
  } state_t;

  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned COUNT_MAX = 255;

  // Debounce counter must be able to hold the value DEBOUNCE itself.
  function automatic int unsigned dbc_cnt_w(input int unsigned debounce);
    return (debounce < 2) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/sensor_monitor_if.sv
// Sensor monitor bus: raw sensors/config from the system, fault status back.
interface sensor_monitor_if #(
  parameter int unsigned NUM_SENSORS = 4
);
  import sensor_pkg::*;

  logic [NUM_SENSORS-1:0] sensors;
  logic [NUM_SENSORS-1:0] sensor_en;
  logic                   clear_error;
  logic                   error;
  logic                   error_latched;
  logic [NUM_SENSORS-1:0] fault_src;
  logic [COUNT_W-1:0]     fault_count;

  modport master (
    output sensors, sensor_en, clear_error,
    input  error, error_latched, fault_src, fault_count
  );

  modport slave (
    input  sensors, sensor_en, clear_error,
    output error, error_latched, fault_src, fault_count
  );

endinterface

// File: rtl/sensor_filter.sv
// One debounce channel: filt follows in only after DEBOUNCE consecutive mismatching samples.
module sensor_filter
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic filt
);

  localparam int unsigned CW = dbc_cnt_w(DEBOUNCE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Any matching sample restarts the streak; the last mismatch of a full streak flips filt.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (in != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        filt_d = in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/sensor_monitor.sv
// Debounced sensor fault monitor: error rule, sticky fault FSM, source capture and entry counter.
module sensor_monitor
  import sensor_pkg::*;
#(
  parameter int unsigned            NUM_SENSORS = 4,
  parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = NUM_SENSORS'(4'b0001),
  parameter int unsigned            ANCHOR_IDX  = 1,
  parameter logic [NUM_SENSORS-1:0] COMP_MASK   = NUM_SENSORS'(4'b1100),
  parameter int unsigned            DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  sensor_monitor_if.slave  mon
);

  localparam logic [NUM_SENSORS-1:0] ANCHOR_MASK = NUM_SENSORS'(1) << ANCHOR_IDX;

  logic [NUM_SENSORS-1:0] filt, act, crit, contrib;
  logic                   pair, rule;

  state_t                 state_q, state_d;
  logic                   error_q, error_d;
  logic                   latched_q, latched_d;
  logic [NUM_SENSORS-1:0] src_q, src_d;
  logic [COUNT_W-1:0]     count_q, count_d;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_filt
    sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .in   (mon.sensors[g]),
      .filt (filt[g])
    );
  end

  // Enables gate the filtered levels directly, so they bypass the debounce.
  always_comb begin
    act     = filt & mon.sensor_en;
    crit    = act & CRIT_MASK;
    pair    = (|(act & ANCHOR_MASK)) & (|(act & COMP_MASK));
    rule    = (|crit) | pair;
    contrib = crit | (pair ? (act & (COMP_MASK | ANCHOR_MASK)) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // A live fault beats a software clear in RECOVERED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:    if (rule) state_d = FAULT;
      FAULT:     if (!rule) state_d = RECOVERED;
      RECOVERED: begin
        if (rule)                  state_d = FAULT;
        else if (mon.clear_error)  state_d = NORMAL;
      end
      default:   state_d = NORMAL;
    endcase
  end

  always_comb begin
    error_d   = (state_d == FAULT);
    latched_d = (state_d != NORMAL);
    src_d     = src_q;
    count_d   = count_q;
    if (state_q == FAULT) begin
      src_d = src_q | contrib;
    end else if (state_q == RECOVERED && state_d == NORMAL) begin
      src_d = '0;
    end
    if (state_d == FAULT && state_q != FAULT && count_q != COUNT_W'(COUNT_MAX)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q   <= 1'b0;
      latched_q <= 1'b0;
      src_q     <= '0;
      count_q   <= '0;
    end else begin
      error_q   <= error_d;
      latched_q <= latched_d;
      src_q     <= src_d;
      count_q   <= count_d;
    end
  end

  assign mon.error         = error_q;
  assign mon.error_latched = latched_q;
  assign mon.fault_src     = src_q;
  assign mon.fault_count   = count_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed self-checking bench for sensor_monitor (4 sensors, DEBOUNCE=3).
module tb_sensor_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sensor_monitor_if #(.NUM_SENSORS(4)) sm_if ();

  sensor_monitor #(
    .NUM_SENSORS (4),
    .CRIT_MASK   (4'b0001),
    .ANCHOR_IDX  (1),
    .COMP_MASK   (4'b1100),
    .DEBOUNCE    (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .mon (sm_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sm_if.sensors     = 4'b0000;
    sm_if.sensor_en   = 4'b1111;
    sm_if.clear_error = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sm_if.sensors     = 4'($urandom);
      sm_if.sensor_en   = 4'($urandom);
      sm_if.clear_error = 1'($urandom);
      tick(1);
      n_cmp++;
      if ({sm_if.error, sm_if.error_latched, sm_if.fault_src, sm_if.fault_count} !== 14'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got err=%b lat=%b src=%b cnt=%0d, want all 0", i,
                 sm_if.error, sm_if.error_latched, sm_if.fault_src, sm_if.fault_count);
      end
    end
    do_reset();
  endtask

  task automatic test_critical();
    do_reset();
    sm_if.sensors = 4'b0001;
    tick(3);
    n_cmp++;
    if (sm_if.error !== 1'b0) begin n_err++; $display("FAIL crit_early: got %b want 0", sm_if.error); end
    tick(1);
    n_cmp++;
    if (sm_if.error !== 1'b1) begin n_err++; $display("FAIL crit_err: got %b want 1", sm_if.error); end
    n_cmp++;
    if (sm_if.fault_count !== 8'd1) begin n_err++; $display("FAIL crit_cnt: got %0d want 1", sm_if.fault_count); end
    n_cmp++;
    if (sm_if.fault_src !== 4'b0000) begin n_err++; $display("FAIL crit_src_entry: got %b want 0000", sm_if.fault_src); end
    sm_if.clear_error = 1'b1;
    tick(1);
    sm_if.clear_error = 1'b0;
    n_cmp++;
    if (sm_if.error_latched !== 1'b1 || sm_if.error !== 1'b1) begin
      n_err++; $display("FAIL clear_in_fault: got err=%b lat=%b want 1 1", sm_if.error, sm_if.error_latched);
    end
    n_cmp++;
    if (sm_if.fault_src !== 4'b0001) begin n_err++; $display("FAIL crit_src: got %b want 0001", sm_if.fault_src); end
    sm_if.sensors = 4'b0000;
    tick(3);
    n_cmp++;
    if (sm_if.error !== 1'b1) begin n_err++; $display("FAIL fall_early: got %b want 1", sm_if.error); end
    tick(1);
    n_cmp++;
    if (sm_if.error !== 1'b0 || sm_if.error_latched !== 1'b1) begin
      n_err++; $display("FAIL recovered: got err=%b lat=%b want 0 1", sm_if.error, sm_if.error_latched);
    end
    sm_if.clear_error = 1'b1;
    tick(1);
    sm_if.clear_error = 1'b0;
    n_cmp++;
    if (sm_if.error_latched !== 1'b0 || sm_if.fault_src !== 4'b0000 || sm_if.fault_count !== 8'd1) begin
      n_err++; $display("FAIL clear_recovered: got lat=%b src=%b cnt=%0d want 0 0000 1",
                        sm_if.error_latched, sm_if.fault_src, sm_if.fault_count);
    end
  endtask

  task automatic test_pair();
    do_reset();
    sm_if.sensors = 4'b0110;
    tick(5);
    n_cmp++;
    if (sm_if.error !== 1'b1 || sm_if.fault_src !== 4'b0110) begin
      n_err++; $display("FAIL pair: got err=%b src=%b want 1 0110", sm_if.error, sm_if.fault_src);
    end
    do_reset();
    sm_if.sensors = 4'b0010;
    tick(6);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0) begin n_err++; $display("FAIL anchor_alone: got %b want 0", sm_if.error_latched); end
    do_reset();
    sm_if.sensors = 4'b1100;
    tick(6);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0) begin n_err++; $display("FAIL comp_alone: got %b want 0", sm_if.error_latched); end
  endtask

  task automatic test_glitch();
    logic [3:0] pat [6];
    pat = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    sm_if.sensors = 4'b0001;
    tick(2);
    sm_if.sensors = 4'b0000;
    tick(6);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0) begin n_err++; $display("FAIL glitch_2cyc: got %b want 0", sm_if.error_latched); end
    for (int i = 0; i < 6; i++) begin
      sm_if.sensors = pat[i];
      tick(1);
    end
    tick(4);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0 || sm_if.fault_count !== 8'd0) begin
      n_err++; $display("FAIL glitch_1011: got lat=%b cnt=%0d want 0 0", sm_if.error_latched, sm_if.fault_count);
    end
  endtask

  task automatic test_refault_clear();
    do_reset();
    sm_if.sensors = 4'b0001;
    tick(5);
    sm_if.sensors = 4'b0000;
    tick(4);
    n_cmp++;
    if (sm_if.error !== 1'b0 || sm_if.error_latched !== 1'b1) begin
      n_err++; $display("FAIL rf_recovered: got err=%b lat=%b want 0 1", sm_if.error, sm_if.error_latched);
    end
    sm_if.sensors = 4'b0001;
    tick(3);
    sm_if.clear_error = 1'b1;
    tick(1);
    sm_if.clear_error = 1'b0;
    n_cmp++;
    if (sm_if.error !== 1'b1 || sm_if.fault_count !== 8'd2 || sm_if.fault_src !== 4'b0001) begin
      n_err++; $display("FAIL rf_clear_vs_fault: got err=%b cnt=%0d src=%b want 1 2 0001",
                        sm_if.error, sm_if.fault_count, sm_if.fault_src);
    end
  endtask

  task automatic test_enable();
    do_reset();
    sm_if.sensor_en = 4'b1110;
    sm_if.sensors   = 4'b0001;
    tick(6);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0) begin n_err++; $display("FAIL en_masked: got %b want 0", sm_if.error_latched); end
    sm_if.sensor_en = 4'b1111;
    tick(1);
    n_cmp++;
    if (sm_if.error !== 1'b1) begin n_err++; $display("FAIL en_immediate: got %b want 1", sm_if.error); end
  endtask

  task automatic test_saturate_and_rst();
    do_reset();
    sm_if.sensor_en = 4'b1110;
    sm_if.sensors   = 4'b0001;
    tick(4);
    for (int i = 0; i < 256; i++) begin
      sm_if.sensor_en = 4'b1111;
      tick(1);
      if (i == 0) begin
        n_cmp++;
        if (sm_if.fault_count !== 8'd1) begin n_err++; $display("FAIL sat_first: got %0d want 1", sm_if.fault_count); end
      end
      sm_if.sensor_en = 4'b1110;
      tick(1);
    end
    n_cmp++;
    if (sm_if.fault_count !== 8'd255 || sm_if.error !== 1'b0) begin
      n_err++; $display("FAIL sat_255: got cnt=%0d err=%b want 255 0", sm_if.fault_count, sm_if.error);
    end
    sm_if.sensor_en = 4'b1111;
    tick(1);
    n_cmp++;
    if (sm_if.error !== 1'b1 || sm_if.fault_count !== 8'd255) begin
      n_err++; $display("FAIL sat_hold: got err=%b cnt=%0d want 1 255", sm_if.error, sm_if.fault_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sm_if.error, sm_if.error_latched, sm_if.fault_src, sm_if.fault_count} !== 14'd0) begin
      n_err++; $display("FAIL rst_mid_fault: got err=%b lat=%b src=%b cnt=%0d want all 0",
                        sm_if.error, sm_if.error_latched, sm_if.fault_src, sm_if.fault_count);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if (sm_if.error_latched !== 1'b0 || sm_if.fault_count !== 8'd0) begin
      n_err++; $display("FAIL rst_filters: got lat=%b cnt=%0d want 0 0", sm_if.error_latched, sm_if.fault_count);
    end
  endtask

  initial begin
    sm_if.sensors     = 4'b0000;
    sm_if.sensor_en   = 4'b1111;
    sm_if.clear_error = 1'b0;
    test_reset();
    test_critical();
    test_pair();
    test_glitch();
    test_refault_clear();
    test_enable();
    test_saturate_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
